ram_sync_clear: RTL and testbench
=================================

Name: ram_sync_clear

Overview:
- Parametrised synchronous single-port RAM; successor to the fixed 8x16 storage block.
- Generalised in width and depth, with a registered read path and a read-valid strobe.
- Has a hardware clear sequencer that zeroes every word after reset and on request.
- Sits as the general-purpose data memory behind datapath and controller blocks in the course designs.

Parameters:
- DATA_WIDTH, 16, bits per word.
- ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH words (default 8).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  access request, sampled each edge.
- write_enable  input  1  1 = write, 0 = read; meaningful only with enable.
- addr  input  ADDR_WIDTH  word address, 0..DEPTH-1.
- dados_in  input  DATA_WIDTH  write data.
- clear_req  input  1  request a full-memory zero sweep.
- dados_out  output  DATA_WIDTH  registered read data.
- read_valid  output  1  one-cycle pulse: dados_out updated this cycle.
- busy  output  1  clear sweep in progress; accesses are dropped.
- access_dropped  output  1  one-cycle pulse: enable was seen while busy.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values (edge with reset=1):
  - dados_out=0, read_valid=0, access_dropped=0.
  - busy=1, state=CLEAR, clear pointer=0.
  - Memory contents are not touched by reset itself; the sweep zeroes them.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each edge writes 0 to mem[ptr] and increments ptr.
  - On the edge that writes ptr==DEPTH-1: state<=READY, busy<=0, ptr<=0.
  - Sweep lasts exactly DEPTH edges after reset deasserts.
  - busy is 1 throughout; it reads 0 at the first cycle in which READY accesses are accepted.
- CLEAR, access handling:
  - enable=1 is ignored (no write, no read, read_valid=0).
  - access_dropped=1 on the following cycle.
  - clear_req is ignored.
- READY, write (enable=1, write_enable=1):
  - mem[addr]<=dados_in at the edge.
  - read_valid=0; dados_out holds.
- READY, read (enable=1, write_enable=0):
  - dados_out<=mem[addr] at the edge; read_valid=1 for that one cycle.
  - Latency is 1 cycle; back-to-back reads give one result per cycle.
- READY, idle (enable=0):
  - dados_out holds its last value; read_valid=0.
- READY, clear_req=1:
  - state<=CLEAR, busy<=1, ptr<=0.
  - clear_req has priority over a simultaneous access, which is dropped (access_dropped pulses).
- Read of an address written on the previous edge returns the new data (no extra hazard).
- addr is always in range by construction (full ADDR_WIDTH decode), so there is no out-of-range case.
- Reset mid-sweep restarts the sweep from ptr=0; reset mid-read clears read_valid and dados_out.
- dados_in and addr are not registered beyond the memory array itself.

Test Plan:
- Reset 2 cycles, release; hold enable=0 → busy=1 for exactly 8 cycles, then 0. Read all addresses 0..7 → each dados_out=16'h0000 with read_valid=1 one cycle after the request.
- After the sweep: write 16'hA5A5 to addr 3, 16'h1234 to addr 7; read 3 then 7 back-to-back → dados_out=16'hA5A5 then 16'h1234 on consecutive cycles, read_valid high both cycles.
- Read addr 3 (gets 16'hA5A5), then hold enable=0 for 4 cycles → dados_out stays 16'hA5A5, read_valid=0.
- Pulse clear_req with a simultaneous write of 16'hFFFF to addr 2 → busy=1 for 8 cycles, access_dropped pulses once, and a read of addr 2 afterwards returns 16'h0000.
- During a sweep, issue enable=1 reads for 3 cycles → access_dropped=1 for 3 cycles, read_valid never asserts.
- Assert reset on the 4th sweep cycle for 1 cycle → busy stays 1 for 8 full cycles after release; re-run with DATA_WIDTH=32, ADDR_WIDTH=5 → sweep lasts 32 cycles and a 32'hDEADBEEF write/read round-trips.

Source files
------------

// File: rtl/ram_sync_clear.sv
// Synchronous single-port RAM with a registered read path, a read-valid strobe and a
// hardware sweep that zeroes every word after reset and whenever clear_req is seen.
module ram_sync_clear #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] dados_in,
  input  logic                  clear_req,
  output logic [DATA_WIDTH-1:0] dados_out,
  output logic                  read_valid,
  output logic                  busy,
  output logic                  access_dropped
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  wr_req_t               wr;

  // The sweep and user writes share the single write port; the sweep owns it in CLEAR.
  always_comb begin
    wr = '0;
    if (!reset) begin
      if (state == CLEAR) begin
        wr.we   = 1'b1;
        wr.addr = ptr;
      end else if (enable && write_enable && !clear_req) begin
        wr.we   = 1'b1;
        wr.addr = addr;
        wr.data = dados_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr.we) mem[wr.addr] <= wr.data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= CLEAR;
      busy           <= 1'b1;
      ptr            <= '0;
      dados_out      <= '0;
      read_valid     <= 1'b0;
      access_dropped <= 1'b0;
    end else begin
      read_valid     <= 1'b0;
      access_dropped <= 1'b0;
      case (state)
        CLEAR: begin
          access_dropped <= enable;
          ptr            <= ptr + 1'b1;
          if (&ptr) begin
            state <= READY;
            busy  <= 1'b0;
            ptr   <= '0;
          end
        end
        READY: begin
          if (clear_req) begin
            // Sweep wins over a simultaneous access, which is reported as dropped.
            state          <= CLEAR;
            busy           <= 1'b1;
            ptr            <= '0;
            access_dropped <= enable;
          end else if (enable && !write_enable) begin
            dados_out  <= mem[addr];
            read_valid <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
          ptr   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_sync_clear.sv
// Bench for ram_sync_clear: table of directed vectors, reset/sweep corner sequences,
// random traffic against a cycle-level model, and a wide/deep instance round-trip.
module tb_ram_sync_clear;
  localparam int DW = 16, AW = 3, DEPTH = 8;
  localparam int BDW = 32, BAW = 5, BDEPTH = 32;

  logic          clk = 1'b0;
  logic          reset, enable, write_enable, clear_req;
  logic [AW-1:0] addr;
  logic [DW-1:0] dados_in, dados_out;
  logic          read_valid, busy, access_dropped;

  logic           b_reset, b_enable, b_write_enable, b_clear_req;
  logic [BAW-1:0] b_addr;
  logic [BDW-1:0] b_dados_in, b_dados_out;
  logic           b_read_valid, b_busy, b_access_dropped;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  ram_sync_clear #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .write_enable(write_enable),
    .addr(addr), .dados_in(dados_in), .clear_req(clear_req),
    .dados_out(dados_out), .read_valid(read_valid), .busy(busy),
    .access_dropped(access_dropped));

  ram_sync_clear #(.DATA_WIDTH(BDW), .ADDR_WIDTH(BAW)) dut_b (
    .clk(clk), .reset(b_reset), .enable(b_enable), .write_enable(b_write_enable),
    .addr(b_addr), .dados_in(b_dados_in), .clear_req(b_clear_req),
    .dados_out(b_dados_out), .read_valid(b_read_valid), .busy(b_busy),
    .access_dropped(b_access_dropped));

  // Reference model: a sweep is "cycles of busy left"; since nothing can read during a
  // sweep, zeroing the whole array when it starts is observationally the same.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_cnt;
  logic [DW-1:0] m_dout;
  logic          m_rv, m_ad;

  function automatic void model(input logic r, en, we, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic c);
    if (r) begin
      m_cnt = DEPTH; m_dout = '0; m_rv = 0; m_ad = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (m_cnt > 0) begin
      m_cnt--; m_rv = 0; m_ad = en;
    end else if (c) begin
      m_cnt = DEPTH; m_rv = 0; m_ad = en;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else begin
      m_ad = 0; m_rv = 0;
      if (en && we) m_mem[a] = d;
      else if (en) begin m_dout = m_mem[a]; m_rv = 1; end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, en, we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic c);
    reset = r; enable = en; write_enable = we; addr = a; dados_in = d; clear_req = c;
    @(posedge clk);
    model(r, en, we, a, d, c);
    #1;
    vectors++;
    chk("dados_out", dados_out, m_dout);
    chk("read_valid", read_valid, m_rv);
    chk("busy", busy, m_cnt > 0);
    chk("access_dropped", access_dropped, m_ad);
  endtask

  typedef struct {
    logic rst, en, we; logic [AW-1:0] a; logic [DW-1:0] d; logic clr;
    logic [DW-1:0] e_dout; logic e_rv, e_busy, e_ad;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic rst, en, we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic clr,
                              input logic [DW-1:0] e_dout, input logic e_rv, e_busy, e_ad);
    vec_t v;
    v.rst = rst; v.en = en; v.we = we; v.a = a; v.d = d; v.clr = clr;
    v.e_dout = e_dout; v.e_rv = e_rv; v.e_busy = e_busy; v.e_ad = e_ad;
    tbl.push_back(v);
  endfunction

  initial begin
    int run;
    reset = 1; enable = 0; write_enable = 0; addr = '0; dados_in = '0; clear_req = 0;
    b_reset = 1; b_enable = 0; b_write_enable = 0; b_addr = '0; b_dados_in = '0; b_clear_req = 0;

    // Directed table: rst en we addr din clr | dout rv busy ad
    for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, AW'(i), 0, 0, 16'h0000, 1, 0, 0);
    add(0, 1, 1, 3, 16'hA5A5, 0, 16'h0000, 0, 0, 0);
    add(0, 1, 1, 7, 16'h1234, 0, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 3, 0, 0, 16'hA5A5, 1, 0, 0);
    add(0, 1, 0, 7, 0, 0, 16'h1234, 1, 0, 0);
    add(0, 1, 0, 3, 0, 0, 16'hA5A5, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 16'hA5A5, 0, 0, 0);
    add(0, 1, 1, 2, 16'hFFFF, 1, 16'hA5A5, 0, 1, 1);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 0, 16'hA5A5, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 16'hA5A5, 0, 0, 0);
    add(0, 1, 0, 2, 0, 0, 16'h0000, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, AW'(i), 0, 0, 16'h0000, 0, 1, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].clr);
      chk($sformatf("tbl[%0d].dout", i), dados_out, tbl[i].e_dout);
      chk($sformatf("tbl[%0d].rv", i), read_valid, tbl[i].e_rv);
      chk($sformatf("tbl[%0d].busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl[%0d].ad", i), access_dropped, tbl[i].e_ad);
    end

    // Reset landing on a read result clears it.
    step(0, 1, 1, 5, 16'h5A5A, 0);
    step(0, 1, 0, 5, 0, 0);
    chk("read_before_reset", dados_out, 16'h5A5A);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_clears_dout", dados_out, 16'h0000);
    chk("reset_clears_rv", read_valid, 1'b0);

    // Reset on the 4th sweep cycle restarts a full-length sweep.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    run = 0;
    while (busy === 1'b1 && run < 40) begin
      run++;
      step(0, 0, 0, 0, 0, 0);
    end
    vectors++;
    chk("busy_len_after_midsweep_reset", run, 8);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      step($urandom_range(63) == 0, $urandom_range(9) < 7, $urandom_range(1) == 1,
           AW'($urandom), DW'($urandom), $urandom_range(31) == 0);

    // Wide/deep instance: sweep length and a full-width round trip.
    @(posedge clk); #1;
    b_reset = 0;
    run = 0;
    while (b_busy === 1'b1 && run < 100) begin
      @(posedge clk); #1;
      run++;
    end
    vectors++;
    chk("b_sweep_len", run, BDEPTH);
    b_enable = 1; b_write_enable = 1; b_addr = 17; b_dados_in = 32'hDEADBEEF;
    @(posedge clk); #1;
    b_write_enable = 0;
    @(posedge clk); #1;
    b_enable = 0;
    vectors++;
    chk("b_roundtrip_data", b_dados_out, 32'hDEADBEEF);
    chk("b_roundtrip_rv", b_read_valid, 1'b1);
    @(posedge clk); #1;
    vectors++;
    chk("b_rv_pulse", b_read_valid, 1'b0);
    chk("b_dout_hold", b_dados_out, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
